// File: rtl/frame_serializer_if.sv
// Handshake and serial-line bundle between the controller datapath and the frame serializer.
interface frame_serializer_if;
   logic       bitTick;
   logic       sendRequest;
   logic [7:0] parallelDataInput;
   logic [1:0] commInitBits;
   logic       serialDataOut;
   logic       busy;
   logic       sendDone;

   modport master (
      output bitTick, sendRequest, parallelDataInput, commInitBits,
      input  serialDataOut, busy, sendDone
   );

   modport slave (
      input  bitTick, sendRequest, parallelDataInput, commInitBits,
      output serialDataOut, busy, sendDone
   );
endinterface

// File: rtl/frame_serializer.sv
// Transmit side of the 11-bit serial control frame: latches a word plus framing bits,
// shifts it out one bit per bitTick, then holds an idle guard gap before signalling done.
module frame_serializer #(
   parameter int unsigned FRAME_BITS = 11,
   parameter bit          PARITY_ODD = 1'b0,
   parameter bit          IDLE_LEVEL = 1'b1,
   parameter int unsigned GUARD_BITS = 2
) (
   input logic               controlClock,
   input logic               resetN,
   frame_serializer_if.slave link
);

   typedef enum logic [1:0] {IDLE, SHIFT, GUARD} stateT;

   localparam logic [3:0] LAST_INDEX = 4'(FRAME_BITS - 1);
   localparam logic [3:0] LAST_GUARD = 4'(GUARD_BITS - 1);

   stateT       state, stateNext;
   logic [10:0] frameReg, frameNext, assembled;
   logic [3:0]  bitIndex, bitIndexNext;
   logic [3:0]  guardCount, guardCountNext;
   logic        lineReg, lineNext;
   logic        busyReg, busyNext;
   logic        doneReg, doneNext;
   logic        accept;

   // Wire order: init[0], data MSB..LSB, parity, init[1]; index 0 goes out first.
   always_comb begin
      assembled     = '0;
      assembled[0]  = link.commInitBits[0];
      for (int i = 0; i < 8; i++) begin
         assembled[1 + i] = link.parallelDataInput[7 - i];
      end
      assembled[9]  = (^link.parallelDataInput) ^ PARITY_ODD;
      assembled[10] = link.commInitBits[1];
   end

   // The sendDone cycle is excluded so a held request restarts one cycle later.
   assign accept = (state == IDLE) && link.sendRequest && !doneReg;

   always_ff @(posedge controlClock or negedge resetN) begin
      if (!resetN) begin
         state      <= IDLE;
         frameReg   <= '0;
         bitIndex   <= '0;
         guardCount <= '0;
         lineReg    <= IDLE_LEVEL;
         busyReg    <= 1'b0;
         doneReg    <= 1'b0;
      end else begin
         state      <= stateNext;
         frameReg   <= frameNext;
         bitIndex   <= bitIndexNext;
         guardCount <= guardCountNext;
         lineReg    <= lineNext;
         busyReg    <= busyNext;
         doneReg    <= doneNext;
      end
   end

   always_comb begin
      stateNext      = state;
      frameNext      = frameReg;
      bitIndexNext   = bitIndex;
      guardCountNext = guardCount;
      lineNext       = lineReg;
      busyNext       = busyReg;
      doneNext       = 1'b0;
      unique case (state)
         IDLE: begin
            lineNext = IDLE_LEVEL;
            busyNext = 1'b0;
            if (accept) begin
               frameNext    = assembled;
               stateNext    = SHIFT;
               busyNext     = 1'b1;
               bitIndexNext = '0;
               lineNext     = assembled[0];
            end
         end
         SHIFT: begin
            if (link.bitTick) begin
               if (bitIndex == LAST_INDEX) begin
                  lineNext = IDLE_LEVEL;
                  if (GUARD_BITS == 0) begin
                     stateNext = IDLE;
                     busyNext  = 1'b0;
                     doneNext  = 1'b1;
                  end else begin
                     stateNext      = GUARD;
                     guardCountNext = '0;
                  end
               end else begin
                  bitIndexNext = bitIndex + 4'd1;
                  lineNext     = frameReg[bitIndex + 4'd1];
               end
            end
         end
         GUARD: begin
            lineNext = IDLE_LEVEL;
            if (link.bitTick) begin
               if (guardCount == LAST_GUARD) begin
                  stateNext = IDLE;
                  busyNext  = 1'b0;
                  doneNext  = 1'b1;
               end else begin
                  guardCountNext = guardCount + 4'd1;
               end
            end
         end
         default: begin
            stateNext = IDLE;
            lineNext  = IDLE_LEVEL;
            busyNext  = 1'b0;
         end
      endcase
   end

   assign link.serialDataOut = lineReg;
   assign link.busy          = busyReg;
   assign link.sendDone      = doneReg;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: one default instance (even parity, 2 guard ticks) and one
// odd-parity, zero-guard instance, checked against a per-tick model of the wire frame.
module tb_frame_serializer;

   logic       controlClock;
   logic       resetN;
   logic       bitTick;
   logic       reqA, reqB;
   logic [7:0] dataIn;
   logic [1:0] initIn;

   int  total = 0;
   int  bad = 0;
   int  doneA = 0, doneB = 0;
   int  overlap = 0;
   bit  recA = 0, recB = 0;
   bit  capA[$], capB[$];
   bit  expA[$], expB[$];
   int  tickWait = 0;

   frame_serializer_if ifA ();
   frame_serializer_if ifB ();

   assign ifA.bitTick           = bitTick;
   assign ifA.sendRequest       = reqA;
   assign ifA.parallelDataInput = dataIn;
   assign ifA.commInitBits      = initIn;
   assign ifB.bitTick           = bitTick;
   assign ifB.sendRequest       = reqB;
   assign ifB.parallelDataInput = dataIn;
   assign ifB.commInitBits      = initIn;

   frame_serializer #(.FRAME_BITS(11), .PARITY_ODD(1'b0), .IDLE_LEVEL(1'b1), .GUARD_BITS(2)) dutA (
      .controlClock(controlClock),
      .resetN      (resetN),
      .link        (ifA.slave)
   );

   frame_serializer #(.FRAME_BITS(11), .PARITY_ODD(1'b1), .IDLE_LEVEL(1'b1), .GUARD_BITS(0)) dutB (
      .controlClock(controlClock),
      .resetN      (resetN),
      .link        (ifB.slave)
   );

   initial begin
      controlClock = 1'b0;
      forever #5 controlClock = ~controlClock;
   end

   // Bit-rate divider stand-in: one-cycle pulse every 4..7 clocks.
   initial begin
      bitTick = 1'b0;
      forever begin
         @(posedge controlClock);
         #1;
         if (tickWait == 0) begin
            bitTick  = 1'b1;
            tickWait = $urandom_range(3, 6);
         end else begin
            bitTick  = 1'b0;
            tickWait = tickWait - 1;
         end
      end
   end

   // Line value seen during each tick period, plus done pulses and busy/done overlap.
   initial begin
      forever begin
         @(negedge controlClock);
         if (recA && bitTick) capA.push_back(ifA.serialDataOut);
         if (recB && bitTick) capB.push_back(ifB.serialDataOut);
         if (ifA.sendDone) doneA++;
         if (ifB.sendDone) doneB++;
         if ((ifA.sendDone && ifA.busy) || (ifB.sendDone && ifB.busy)) overlap++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference frame: what a receiver sampling once per tick should see, guard included.
   task automatic modelFrame(input int which, input logic [7:0] d, input logic [1:0] ini);
      bit  line[$];
      int  ones;
      bit  par;
      bit  odd;
      int  guard;
      odd   = (which == 0) ? 1'b0 : 1'b1;
      guard = (which == 0) ? 2 : 0;
      ones  = 0;
      line.push_back(ini[0]);
      for (int i = 7; i >= 0; i--) begin
         line.push_back(d[i]);
         if (d[i]) ones++;
      end
      par = ((ones % 2) == 1);
      if (odd) par = !par;
      line.push_back(par);
      line.push_back(ini[1]);
      for (int g = 0; g < guard; g++) line.push_back(1'b1);
      foreach (line[k]) begin
         if (which == 0) expA.push_back(line[k]);
         else            expB.push_back(line[k]);
      end
   endtask

   task automatic clearRecord(input int which);
      if (which == 0) begin
         recA = 0; capA.delete(); expA.delete();
      end else begin
         recB = 0; capB.delete(); expB.delete();
      end
   endtask

   task automatic applyStimulus(input int which, input logic [7:0] d, input logic [1:0] ini,
                                input bit hold, input string tag);
      clearRecord(which);
      @(posedge controlClock);
      #1;
      dataIn = d;
      initIn = ini;
      if (which == 0) reqA = 1'b1; else reqB = 1'b1;
      @(posedge controlClock);
      #1;
      if (which == 0) begin
         recA = 1;
         if (!hold) reqA = 1'b0;
         checkOutput({tag, ".busyAfterAccept"}, ifA.busy, 1);
         checkOutput({tag, ".firstBit"}, ifA.serialDataOut, ini[0]);
      end else begin
         recB = 1;
         if (!hold) reqB = 1'b0;
         checkOutput({tag, ".busyAfterAccept"}, ifB.busy, 1);
         checkOutput({tag, ".firstBit"}, ifB.serialDataOut, ini[0]);
      end
      modelFrame(which, d, ini);
   endtask

   task automatic waitDone(input int which, input int target, input string tag);
      int n;
      n = 0;
      while (((which == 0) ? doneA : doneB) < target && n < 600) begin
         @(posedge controlClock);
         #1;
         n++;
      end
      checkOutput({tag, ".doneCount"}, (which == 0) ? doneA : doneB, target);
   endtask

   task automatic compareFrame(input int which, input string tag);
      bit got[$];
      bit want[$];
      int n;
      if (which == 0) begin got = capA; want = expA; end
      else            begin got = capB; want = expB; end
      checkOutput({tag, ".tickCount"}, got.size(), want.size());
      n = (got.size() < want.size()) ? got.size() : want.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s.bit%0d", tag, i), got[i], want[i]);
      end
      if (which == 0) recA = 0; else recB = 0;
   endtask

   initial begin
      logic [7:0] rxData;
      logic [7:0] d;
      logic [1:0] ini;
      int         w;
      int         base;

      resetN = 1'b0;
      reqA   = 1'b0;
      reqB   = 1'b0;
      dataIn = '0;
      initIn = '0;
      repeat (3) @(posedge controlClock);
      #1;
      checkOutput("reset.lineA", ifA.serialDataOut, 1);
      checkOutput("reset.busyA", ifA.busy, 0);
      checkOutput("reset.doneA", ifA.sendDone, 0);
      checkOutput("reset.lineB", ifB.serialDataOut, 1);
      checkOutput("reset.busyB", ifB.busy, 0);
      resetN = 1'b1;
      repeat (2) @(posedge controlClock);

      // Directed A5 frame with receive-side decode.
      applyStimulus(0, 8'hA5, 2'b10, 0, "a5");
      waitDone(0, 1, "a5");
      compareFrame(0, "a5");
      for (int i = 0; i < 8; i++) rxData[7 - i] = capA[1 + i];
      checkOutput("a5.rxData", rxData, 8'hA5);
      checkOutput("a5.rxParity", capA[9], 0);
      checkOutput("a5.rxInit", {capA[10], capA[0]}, 2'b10);
      checkOutput("a5.busyAtEnd", ifA.busy, 0);

      // Odd parity on the zero-guard instance.
      applyStimulus(1, 8'h07, 2'b01, 0, "odd07");
      waitDone(1, 1, "odd07");
      checkOutput("odd07.parity", capB[9], 0);
      compareFrame(1, "odd07");
      applyStimulus(1, 8'h03, 2'b11, 0, "odd03");
      waitDone(1, 2, "odd03");
      checkOutput("odd03.parity", capB[9], 1);
      compareFrame(1, "odd03");

      // Request pulsed while busy must not disturb the in-flight frame.
      applyStimulus(0, 8'h5A, 2'b01, 0, "busyReq");
      repeat (15) @(posedge controlClock);
      #1;
      dataIn = 8'hFF;
      initIn = 2'b00;
      reqA   = 1'b1;
      @(posedge controlClock);
      #1;
      reqA = 1'b0;
      waitDone(0, 2, "busyReq");
      compareFrame(0, "busyReq");
      repeat (40) @(posedge controlClock);
      #1;
      checkOutput("busyReq.singleDone", doneA, 2);
      checkOutput("busyReq.idleBusy", ifA.busy, 0);

      // Back-to-back with request held high, guard gap between frames.
      applyStimulus(0, 8'h3C, 2'b10, 1, "b2bA");
      dataIn = 8'hC3;
      initIn = 2'b01;
      modelFrame(0, 8'hC3, 2'b01);
      waitDone(0, 4, "b2bA");
      reqA = 1'b0;
      compareFrame(0, "b2bA");

      d = 8'($urandom);
      applyStimulus(1, d, 2'b10, 1, "b2bB");
      dataIn = ~d;
      initIn = 2'b01;
      modelFrame(1, ~d, 2'b01);
      waitDone(1, 4, "b2bB");
      reqB = 1'b0;
      compareFrame(1, "b2bB");

      // Request accepted on a cycle where bitTick is also high.
      clearRecord(0);
      w = 0;
      while (!(bitTick && !ifA.busy) && w < 50) begin
         @(negedge controlClock);
         w++;
      end
      dataIn = 8'h96;
      initIn = 2'b11;
      reqA   = 1'b1;
      @(posedge controlClock);
      #1;
      recA = 1;
      reqA = 1'b0;
      checkOutput("tickAccept.busy", ifA.busy, 1);
      modelFrame(0, 8'h96, 2'b11);
      waitDone(0, 5, "tickAccept");
      compareFrame(0, "tickAccept");

      // Randomized frames on either instance.
      for (int r = 0; r < 6; r++) begin
         w    = $urandom_range(0, 1);
         d    = 8'($urandom);
         ini  = 2'($urandom);
         base = (w == 0) ? doneA : doneB;
         applyStimulus(w, d, ini, 0, $sformatf("rand%0d", r));
         waitDone(w, base + 1, $sformatf("rand%0d", r));
         compareFrame(w, $sformatf("rand%0d", r));
      end

      // Asynchronous reset in the middle of a frame.
      base = doneA;
      applyStimulus(0, 8'h00, 2'b00, 0, "midReset");
      repeat (20) @(posedge controlClock);
      #3;
      resetN = 1'b0;
      #1;
      checkOutput("midReset.line", ifA.serialDataOut, 1);
      checkOutput("midReset.busy", ifA.busy, 0);
      checkOutput("midReset.done", ifA.sendDone, 0);
      clearRecord(0);
      repeat (3) @(posedge controlClock);
      #1;
      resetN = 1'b1;
      repeat (60) @(posedge controlClock);
      #1;
      checkOutput("midReset.noDone", doneA, base);

      checkOutput("doneBusyOverlap", overlap, 0);
      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
